// File: rtl/kda_job_assembler.sv
// kda_job_assembler: frames a header word, password words and salt words from the host
// into one parallel PBKDF2 job held on a valid/ready port until consumed.
module kda_job_assembler #(
   parameter int PASS_WORDS = 8,
   parameter int SALT_WORDS = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [63:0]              data_i,
   input  logic                     v_i,
   output logic                     ready_o,
   output logic [1:0]               chunks_o,
   output logic [5:0]               salt_len_o,
   output logic [31:0]              iters_o,
   output logic [64*PASS_WORDS-1:0] pass_o,
   output logic [64*SALT_WORDS-1:0] salt_o,
   output logic                     v_o,
   input  logic                     ready_i,
   output logic                     err_o
);
   localparam int PW = 64 * PASS_WORDS;
   localparam int SW = 64 * SALT_WORDS;
   localparam int MAXW = PASS_WORDS > SALT_WORDS ? PASS_WORDS : SALT_WORDS;
   localparam int CW = $clog2(MAXW) + 1;
   localparam logic [CW-1:0] PASS_LAST = CW'(PASS_WORDS - 1);
   localparam logic [CW-1:0] SALT_LAST = CW'(SALT_WORDS - 1);
   localparam logic [1:0] HDR  = 2'd0;
   localparam logic [1:0] PASS = 2'd1;
   localparam logic [1:0] SALT = 2'd2;
   localparam logic [1:0] FULL = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          drop_q, drop_d;
   logic          err_q, err_d;
   logic [1:0]    chunks_q, chunks_d;
   logic [5:0]    salt_len_q, salt_len_d;
   logic [31:0]   iters_q, iters_d;
   logic [PW-1:0] pass_q, pass_d;
   logic [SW-1:0] salt_q, salt_d;
   logic          in_xfer;
   logic          unused_rsvd;

   assign ready_o     = ~reset_i & (state_q != FULL);
   assign in_xfer     = v_i & ready_o;
   assign unused_rsvd = ^data_i[23:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      drop_d     = drop_q;
      err_d      = 1'b0;
      chunks_d   = chunks_q;
      salt_len_d = salt_len_q;
      iters_d    = iters_q;
      pass_d     = pass_q;
      salt_d     = salt_q;
      if (in_xfer && state_q == HDR) begin
         chunks_d   = data_i[63:62];
         salt_len_d = data_i[61:56];
         iters_d    = data_i[55:24];
         cnt_d      = '0;
         drop_d     = data_i[55:24] == 32'd0;
         err_d      = data_i[55:24] == 32'd0;
         state_d    = PASS;
      end
      if (in_xfer && state_q == PASS) begin
         pass_d  = PW'({pass_q, data_i});
         cnt_d   = cnt_q == PASS_LAST ? '0 : cnt_q + CW'(1);
         state_d = cnt_q == PASS_LAST ? SALT : PASS;
      end
      // A dropped (zero-iteration) job is fully consumed from the host but never presented.
      if (in_xfer && state_q == SALT) begin
         salt_d  = SW'({salt_q, data_i});
         cnt_d   = cnt_q == SALT_LAST ? '0 : cnt_q + CW'(1);
         state_d = cnt_q == SALT_LAST ? (drop_q ? HDR : FULL) : SALT;
      end
      if (state_q == FULL && ready_i) state_d = HDR;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= HDR;
         cnt_q      <= '0;
         drop_q     <= 1'b0;
         err_q      <= 1'b0;
         chunks_q   <= '0;
         salt_len_q <= '0;
         iters_q    <= '0;
         pass_q     <= '0;
         salt_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
         chunks_q   <= chunks_d;
         salt_len_q <= salt_len_d;
         iters_q    <= iters_d;
         pass_q     <= pass_d;
         salt_q     <= salt_d;
      end
   end

   assign v_o        = state_q == FULL;
   assign err_o      = err_q;
   assign chunks_o   = chunks_q;
   assign salt_len_o = salt_len_q;
   assign iters_o    = iters_q;
   assign pass_o     = pass_q;
   assign salt_o     = salt_q;
endmodule
